// File: rtl/ddr_tx_serializer.sv
// Parallel-to-DDR transmit serializer: takes words over valid/ready and emits
// one rise/fall bit pair per clock, with frame/sof/eof strobes for realignment.
module ddr_tx_serializer #(
   parameter int unsigned DATA_W    = 16,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_VAL  = 1'b0
) (
   input  logic              c_clk_i,
   input  logic              c_rst_i,
   input  logic [DATA_W-1:0] d_data_i,
   input  logic              d_valid_i,
   output logic              d_ready_o,
   output logic              d_rise_o,
   output logic              d_fall_o,
   output logic              d_frame_o,
   output logic              d_sof_o,
   output logic              d_eof_o,
   output logic              d_busy_o
);

   localparam int unsigned NPAIR = DATA_W / 2;
   localparam int unsigned CNT_W = $clog2(NPAIR);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPAIR - 1);

   if ((DATA_W < 4) || ((DATA_W % 2) != 0)) begin : g_bad_data_w
      $error("ddr_tx_serializer: DATA_W must be even and >= 4");
   end

   logic [DATA_W-1:0] sh_q,  sh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              act_q, act_d;
   logic [DATA_W-1:0] hb_q,  hb_d;
   logic              hbv_q, hbv_d;

   logic              xfer;
   logic              at_last;
   logic [DATA_W-1:0] sh_shifted;
   logic              cur_rise;
   logic              cur_fall;

   assign xfer    = d_valid_i && !hbv_q;
   assign at_last = (cnt_q == CNT_LAST);

   // The pair on the lanes always sits at the outgoing end of the shifter.
   assign sh_shifted = MSB_FIRST ? {sh_q[DATA_W-3:0], 2'b00} : {2'b00, sh_q[DATA_W-1:2]};
   assign cur_rise   = MSB_FIRST ? sh_q[DATA_W-1] : sh_q[0];
   assign cur_fall   = MSB_FIRST ? sh_q[DATA_W-2] : sh_q[1];

   // Word-load / shift sequencing; a finishing word hands over without a gap.
   always_comb begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
      act_d = act_q;
      hb_d  = hb_q;
      hbv_d = hbv_q;
      if (!act_q) begin
         if (xfer) begin
            sh_d  = d_data_i;
            cnt_d = '0;
            act_d = 1'b1;
         end
      end else if (!at_last) begin
         sh_d  = sh_shifted;
         cnt_d = cnt_q + CNT_W'(1);
         if (xfer) begin
            hb_d  = d_data_i;
            hbv_d = 1'b1;
         end
      end else if (hbv_q) begin
         sh_d  = hb_q;
         hbv_d = 1'b0;
         cnt_d = '0;
      end else if (xfer) begin
         sh_d  = d_data_i;
         cnt_d = '0;
      end else begin
         act_d = 1'b0;
      end
   end

   always_ff @(posedge c_clk_i) begin
      if (c_rst_i) begin
         sh_q  <= '0;
         cnt_q <= '0;
         act_q <= 1'b0;
         hb_q  <= '0;
         hbv_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
         act_q <= act_d;
         hb_q  <= hb_d;
         hbv_q <= hbv_d;
      end
   end

   // Outputs decode flops only; nothing here depends on d_valid_i.
   assign d_ready_o = !hbv_q;
   assign d_rise_o  = act_q ? cur_rise : IDLE_VAL;
   assign d_fall_o  = act_q ? cur_fall : IDLE_VAL;
   assign d_frame_o = act_q;
   assign d_sof_o   = act_q && (cnt_q == '0);
   assign d_eof_o   = act_q && at_last;
   assign d_busy_o  = act_q || hbv_q;

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Bench for ddr_tx_serializer: MSB-first and LSB-first instances share stimulus
// and are compared each cycle against a queue-based word-stream model.
module tb_ddr_tx_serializer;

   localparam int unsigned W  = 8;
   localparam int unsigned NP = W / 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] data;
   logic         valid;

   logic m_ready, m_rise, m_fall, m_frame, m_sof, m_eof, m_busy;
   logic l_ready, l_rise, l_fall, l_frame, l_sof, l_eof, l_busy;

   int errors = 0;
   int checks = 0;

   // Model: word currently on the lanes (cur_k = pair index, -1 idle) plus words
   // accepted but not yet started.
   logic [W-1:0] pend[$];
   logic [W-1:0] cur_w;
   int           cur_k;

   always #5 clk = ~clk;

   ddr_tx_serializer #(.DATA_W(W), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) u_msb (
      .c_clk_i(clk), .c_rst_i(rst), .d_data_i(data), .d_valid_i(valid),
      .d_ready_o(m_ready), .d_rise_o(m_rise), .d_fall_o(m_fall),
      .d_frame_o(m_frame), .d_sof_o(m_sof), .d_eof_o(m_eof), .d_busy_o(m_busy)
   );

   ddr_tx_serializer #(.DATA_W(W), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0)) u_lsb (
      .c_clk_i(clk), .c_rst_i(rst), .d_data_i(data), .d_valid_i(valid),
      .d_ready_o(l_ready), .d_rise_o(l_rise), .d_fall_o(l_fall),
      .d_frame_o(l_frame), .d_sof_o(l_sof), .d_eof_o(l_eof), .d_busy_o(l_busy)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Expected {0,ready,busy,frame,sof,eof,rise,fall} for one bit ordering.
   function automatic logic [7:0] exp_vec(input bit msb);
      logic act, rise, fall, sof, eof;
      act  = (cur_k >= 0);
      rise = 1'b0;
      fall = 1'b0;
      if (act) begin
         rise = msb ? cur_w[W-1-2*cur_k] : cur_w[2*cur_k];
         fall = msb ? cur_w[W-2-2*cur_k] : cur_w[2*cur_k+1];
      end
      sof = act && (cur_k == 0);
      eof = act && (cur_k == NP - 1);
      return {1'b0, pend.size() == 0, act || (pend.size() != 0), act, sof, eof, rise, fall};
   endfunction

   task automatic model_edge(input logic r, input logic v, input logic [W-1:0] d);
      bit acc;
      if (r) begin
         pend.delete();
         cur_k = -1;
         return;
      end
      acc = v && (pend.size() == 0);
      if (cur_k >= 0 && cur_k < NP - 1) begin
         cur_k++;
         if (acc) pend.push_back(d);
      end else if (pend.size() != 0) begin
         cur_w = pend.pop_front();
         cur_k = 0;
      end else if (acc) begin
         cur_w = d;
         cur_k = 0;
      end else begin
         cur_k = -1;
      end
   endtask

   // Drive inputs, take one rising edge, then compare both instances mid-cycle.
   task automatic step(input logic r, input logic v, input logic [W-1:0] d, input string tag);
      rst   = r;
      valid = v;
      data  = d;
      @(posedge clk);
      model_edge(r, v, d);
      @(negedge clk);
      chk({tag, "_msb"}, {1'b0, m_ready, m_busy, m_frame, m_sof, m_eof, m_rise, m_fall}, exp_vec(1'b1));
      chk({tag, "_lsb"}, {1'b0, l_ready, l_busy, l_frame, l_sof, l_eof, l_rise, l_fall}, exp_vec(1'b0));
   endtask

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      data  = '0;
      cur_w = '0;
      cur_k = -1;
      @(negedge clk);

      // Reset, then idle
      step(1'b1, 1'b0, 8'h00, "rst0");
      step(1'b1, 1'b0, 8'h00, "rst1");
      chk("rst_idle", {1'b0, m_ready, m_busy, m_frame, m_sof, m_eof, m_rise, m_fall}, 8'h40);
      step(1'b0, 1'b0, 8'h00, "idle");

      // Single word 0xB4 with fixed expected pairs
      step(1'b0, 1'b1, 8'hB4, "b4_p0");
      chk("b4_msb_p0", {6'd0, m_rise, m_fall}, 8'h2);
      chk("b4_lsb_p0", {6'd0, l_rise, l_fall}, 8'h0);
      step(1'b0, 1'b0, 8'h00, "b4_p1");
      chk("b4_msb_p1", {6'd0, m_rise, m_fall}, 8'h3);
      chk("b4_lsb_p1", {6'd0, l_rise, l_fall}, 8'h2);
      step(1'b0, 1'b0, 8'h00, "b4_p2");
      chk("b4_msb_p2", {6'd0, m_rise, m_fall}, 8'h1);
      chk("b4_lsb_p2", {6'd0, l_rise, l_fall}, 8'h3);
      step(1'b0, 1'b0, 8'h00, "b4_p3");
      chk("b4_msb_p3", {5'd0, m_eof, m_rise, m_fall}, 8'h4);
      chk("b4_lsb_p3", {5'd0, l_eof, l_rise, l_fall}, 8'h5);
      step(1'b0, 1'b0, 8'h00, "b4_end");
      chk("b4_end_frame", {7'd0, m_frame}, 8'h0);

      // Back-to-back 0xB4 then 0x5A, valid held
      step(1'b0, 1'b1, 8'hB4, "bb_a0");
      step(1'b0, 1'b1, 8'h5A, "bb_a1");
      chk("bb_ready_low", {7'd0, m_ready}, 8'h0);
      step(1'b0, 1'b0, 8'h00, "bb_a2");
      step(1'b0, 1'b0, 8'h00, "bb_a3");
      step(1'b0, 1'b0, 8'h00, "bb_b0");
      chk("bb_b0_sof_pair", {4'd0, m_frame, m_sof, m_rise, m_fall}, 8'hD);
      step(1'b0, 1'b0, 8'h00, "bb_b1");
      chk("bb_b1_pair", {6'd0, m_rise, m_fall}, 8'h1);
      step(1'b0, 1'b0, 8'h00, "bb_b2");
      chk("bb_b2_pair", {6'd0, m_rise, m_fall}, 8'h2);
      step(1'b0, 1'b0, 8'h00, "bb_b3");
      chk("bb_b3_pair", {6'd0, m_rise, m_fall}, 8'h2);
      step(1'b0, 1'b0, 8'h00, "bb_idle");

      // Reset mid-frame with the holding buffer full
      step(1'b0, 1'b1, 8'hB4, "mr_p0");
      step(1'b0, 1'b1, 8'h5A, "mr_p1");
      step(1'b0, 1'b0, 8'h00, "mr_p2");
      step(1'b1, 1'b0, 8'h00, "mr_rst");
      chk("mr_after_rst", {1'b0, m_ready, m_busy, m_frame, m_sof, m_eof, m_rise, m_fall}, 8'h40);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, "mr_quiet");

      // Backpressure: valid held while data changes every cycle
      step(1'b0, 1'b1, 8'hB4, "bp_a");
      step(1'b0, 1'b1, 8'h11, "bp_b");
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'h22 + 8'(i * 8'h11)), "bp_hold");
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, "bp_drain");

      // Randomized traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
              8'($urandom_range(0, 255)), "rnd");
      end
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, "tail");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ddr_tx_serializer.md
Name: ddr_tx_serializer

Overview:
- Transmit-side companion to the team's double-edge capture registers.
- Accepts parallel words over a valid/ready handshake and emits two bits per clock on a rise lane and a fall lane. A downstream double-edge output stage launches the rise lane on posedge and the fall lane on negedge.
- Adds frame-delimiting strobes so the far-end receiver can realign words.
- Sits between packet logic and the DDR pin stage.

Parameters:
- DATA_W, 16: word width in bits. Must be even and ≥ 4; other values are a build-time error.
- MSB_FIRST, 1: 1 sends bit DATA_W-1 first on the rise lane; 0 sends bit 0 first on the rise lane.
- IDLE_VAL, 0: value driven on both lanes when no word is being sent.

Ports:
- c_clk_i  in  1  single clock; all logic on its rising edge.
- c_rst_i  in  1  reset, synchronous, active-high.
- d_data_i  in  DATA_W  word to send.
- d_valid_i  in  1  d_data_i is valid.
- d_ready_o  out  1  block can take a word this cycle.
- d_rise_o  out  1  bit for the posedge launch.
- d_fall_o  out  1  bit for the negedge launch.
- d_frame_o  out  1  high while the lanes carry word bits.
- d_sof_o  out  1  high on the first bit pair of a word.
- d_eof_o  out  1  high on the last bit pair of a word.
- d_busy_o  out  1  shifter active or holding buffer occupied.

Behaviour:
- One clock, synchronous active-high reset on c_clk_i / c_rst_i.
- Internal state:
  - shifter sh[DATA_W-1:0]
  - pair counter cnt, width clog2(DATA_W/2)
  - active flag act
  - one-word holding buffer hb with valid flag hbv
- Reset (synchronous, takes priority over every other action):
  - act=0, hbv=0, cnt=0, sh=0.
  - Outputs: d_ready_o=1, d_rise_o=d_fall_o=IDLE_VAL, d_frame_o=d_sof_o=d_eof_o=0, d_busy_o=0.
  - A word that is mid-frame is discarded and is not resumed.
- d_ready_o = !hbv. It is driven from a register only and has no combinational path from d_valid_i.
- A transfer occurs on a rising edge where d_valid_i && d_ready_o.
- States:
  - IDLE (act=0): lanes at IDLE_VAL; frame, sof, eof all 0.
  - SEND (act=1): lanes show the current pair; cnt counts 0 .. DATA_W/2-1.
- Pair ordering:
  - MSB_FIRST=1: pair k is rise=word[DATA_W-1-2k], fall=word[DATA_W-2-2k].
  - MSB_FIRST=0: pair k is rise=word[2k], fall=word[2k+1].
- Lane outputs and strobes are combinational from registers only: sof=(act && cnt==0), eof=(act && cnt==DATA_W/2-1).
- Word-load rules, evaluated each edge:
  - IDLE plus transfer: load the word into sh, act=1, cnt=0. Pair 0 appears in the cycle after the accept edge, so latency is 1 cycle.
  - SEND with cnt<last: shift by 2 and cnt++. A transfer in this cycle goes to hb (hbv=1).
  - SEND with cnt==last and hbv=1: load hb into sh, hbv=0, cnt=0. This is gapless and the next cycle shows sof.
  - SEND with cnt==last, hbv=0, and a transfer: load the incoming word straight into sh, cnt=0. This is gapless.
  - SEND with cnt==last, hbv=0, and no transfer: act=0, return to IDLE.
- Sustained throughput is one word per DATA_W/2 cycles with no idle cycle between back-to-back words.
- d_busy_o = act || hbv.
- d_data_i is sampled only on the transfer edge. Later changes to it have no effect.
- d_valid_i while d_ready_o=0: nothing is taken. The upstream side must hold the word, per standard valid/ready.

Test Plan:
- Reset then idle, DATA_W=8, MSB_FIRST=1:
  - Assert c_rst_i for 2 cycles -> d_ready_o=1, lanes=0, frame/sof/eof=0, busy=0.
- Single word 0xB4, MSB_FIRST=1:
  - Transfer at edge k -> cycles k+1..k+4 carry rise/fall pairs (1,0),(1,1),(0,1),(0,0).
  - sof only at k+1, eof only at k+4, frame high for exactly 4 cycles, IDLE at k+5.
- Same word 0xB4, MSB_FIRST=0:
  - -> pairs (0,0),(1,0),(1,1),(0,1).
- Back-to-back, valid held high with 0xB4 then 0x5A:
  - Second word is accepted into hb during the first frame, and d_ready_o=0 until hb drains.
  - eof(0xB4) is immediately followed by sof(0x5A) with frame staying high, pairs (0,1),(0,1),(1,0),(1,0).
- Reset mid-frame:
  - Assert c_rst_i at cnt=2 of 0xB4 with hbv=1 -> the next cycle is idle, hb is discarded, d_ready_o=1, and no further pairs of either word appear.
- Backpressure hold:
  - d_valid_i held while d_ready_o=0 and d_data_i changes between cycles -> only the value present on the transfer edge is sent.
